alu_host: RTL and testbench

Command-side initiator for the ALU register interface. It accepts one operation at a time over a valid/ready command port and drives the ALU's enable, op-select and operand inputs for exactly one cycle. It then samples `alu_out` and `alu_irq`, clears a raised interrupt with a one-cycle `alu_irq_clr` pulse, and returns the result on a valid/ready response port. It sits between a bus-side command source and the ALU, and owns the ALU's `alu_irq_clr`.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_host_if.sv | 23 ++
 rtl/alu_host.sv | 96 +++++++++
 tb/tb_alu_host.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared modes, host FSM states, ALU op tables and interrupt triggers.
package alu_pkg;
  typedef enum logic [1:0] {
    MODE_A   = 2'b00,
    MODE_B   = 2'b01,
    MODE_ILL = 2'b10,
    MODE_NOP = 2'b11
  } alu_mode_e;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_CLEAR, S_RESP} host_state_e;
  localparam logic [1:0] OP_A_AND  = 2'b00;
  localparam logic [1:0] OP_A_XOR  = 2'b01;
  localparam logic [1:0] OP_A_OR   = 2'b10;
  localparam logic [1:0] OP_A_ADD  = 2'b11;
  localparam logic [1:0] OP_B_NOR  = 2'b00;
  localparam logic [1:0] OP_B_SUB  = 2'b01;
  localparam logic [1:0] OP_B_XNOR = 2'b10;
  localparam logic [1:0] OP_B_XOR  = 2'b11;
  localparam logic [7:0] IRQ_A_TRIG [4] = '{8'hF8, 8'h83, 8'hFF, 8'h00};
  localparam logic [7:0] IRQ_B_TRIG [4] = '{8'hF1, 8'hF4, 8'hF5, 8'hFF};
  function automatic logic irq_hit(input logic is_b, input logic [7:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      hit |= v == (is_b ? IRQ_B_TRIG[i] : IRQ_A_TRIG[i]);
    return hit;
  endfunction
endpackage

// File: rtl/alu_host_if.sv
// alu_host_if: command and response handshake bundle between a bus source and alu_host.
interface alu_host_if;
  import alu_pkg::*;
  logic       cmd_valid;
  logic       cmd_ready;
  alu_mode_e  cmd_mode;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_irq;
  logic       rsp_err;
  modport master (
    output cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_irq, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_irq, rsp_err
  );
endinterface

// File: rtl/alu_host.sv
// alu_host: one-at-a-time command initiator driving the ALU and returning its result and interrupt.
module alu_host
  import alu_pkg::*;
#(
  parameter int IRQ_CNT_W = 8
) (
  input  logic                 alu_clk,
  input  logic                 rst,
  alu_host_if.slave            bus,
  output logic                 alu_enable,
  output logic                 alu_enable_a,
  output logic                 alu_enable_b,
  output logic [1:0]           alu_op_a,
  output logic [1:0]           alu_op_b,
  output logic [7:0]           alu_in_a,
  output logic [7:0]           alu_in_b,
  output logic                 alu_irq_clr,
  input  logic [7:0]           alu_out,
  input  logic                 alu_irq,
  output logic [IRQ_CNT_W-1:0] irq_count,
  output logic                 busy
);
  host_state_e state;
  assign busy = state != S_IDLE;
  always_ff @(posedge alu_clk or posedge rst)
    if (rst) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_irq   <= 1'b0;
      bus.rsp_err   <= 1'b0;
      alu_enable    <= 1'b0;
      alu_enable_a  <= 1'b0;
      alu_enable_b  <= 1'b0;
      alu_op_a      <= '0;
      alu_op_b      <= '0;
      alu_in_a      <= '0;
      alu_in_b      <= '0;
      alu_irq_clr   <= 1'b0;
      irq_count     <= '0;
    end else begin
      alu_enable   <= 1'b0;
      alu_enable_a <= 1'b0;
      alu_enable_b <= 1'b0;
      alu_irq_clr  <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.cmd_ready <= 1'b1;
          // NOP commands are swallowed here and leave the host ready
          if (bus.cmd_valid && bus.cmd_ready && bus.cmd_mode != MODE_NOP) begin
            bus.cmd_ready <= 1'b0;
            if (bus.cmd_mode == MODE_ILL) begin
              bus.rsp_data <= '0;
              bus.rsp_irq  <= 1'b0;
              bus.rsp_err  <= 1'b1;
              state        <= S_RESP;
            end else begin
              alu_enable   <= 1'b1;
              alu_enable_a <= bus.cmd_mode == MODE_A;
              alu_enable_b <= bus.cmd_mode == MODE_B;
              alu_op_a     <= bus.cmd_mode == MODE_A ? bus.cmd_op : 2'b00;
              alu_op_b     <= bus.cmd_mode == MODE_B ? bus.cmd_op : 2'b00;
              alu_in_a     <= bus.cmd_a;
              alu_in_b     <= bus.cmd_b;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_CAPTURE;
        S_CAPTURE: begin
          bus.rsp_data <= alu_out;
          bus.rsp_irq  <= alu_irq;
          bus.rsp_err  <= 1'b0;
          if (alu_irq) begin
            if (irq_count != '1) irq_count <= irq_count + 1'b1;
            alu_irq_clr <= 1'b1;
            state       <= S_CLEAR;
          end else begin
            state <= S_RESP;
          end
        end
        S_CLEAR: state <= S_RESP;
        S_RESP:
          // valid is raised one cycle after entering RESP, then held until taken
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_host.sv
// tb_alu_host: directed and randomized checks of alu_host against a behavioural ALU and host model.
module tb_alu_host;
  import alu_pkg::*;
  logic alu_clk = 1'b0;
  logic rst = 1'b0;
  always #5 alu_clk = ~alu_clk;
  alu_host_if bus ();
  logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, alu_irq;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b, alu_out;
  logic [7:0] irq_count;
  logic       busy;
  logic       inject_irq = 1'b0;
  int compared = 0, mismatched = 0, en_both = 0;
  alu_host #(.IRQ_CNT_W(8)) dut (
    .alu_clk(alu_clk), .rst(rst), .bus(bus),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq),
    .irq_count(irq_count), .busy(busy)
  );

  function automatic logic [7:0] alu_fn(input logic is_b, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (!is_b)
      case (op)
        OP_A_AND: return a & b;
        OP_A_XOR: return a ^ b;
        OP_A_OR:  return a | b;
        default:  return a + b;
      endcase
    case (op)
      OP_B_NOR:  return ~(a | b);
      OP_B_SUB:  return a - b;
      OP_B_XNOR: return ~(a ^ b);
      default:   return a ^ b;
    endcase
  endfunction

  // behavioural ALU: registered result, sticky interrupt cleared by alu_irq_clr
  logic [7:0] alu_out_r = '0;
  logic       alu_irq_r = 1'b0;
  assign alu_out = alu_out_r;
  assign alu_irq = alu_irq_r;
  always @(posedge alu_clk) begin
    if (alu_irq_clr) alu_irq_r <= 1'b0;
    if (inject_irq) alu_irq_r <= 1'b1;
    if (alu_enable && (alu_enable_a || alu_enable_b)) begin
      alu_out_r <= alu_fn(alu_enable_b, alu_enable_a ? alu_op_a : alu_op_b, alu_in_a, alu_in_b);
      if (irq_hit(alu_enable_b, alu_fn(alu_enable_b, alu_enable_a ? alu_op_a : alu_op_b, alu_in_a, alu_in_b)))
        alu_irq_r <= 1'b1;
    end
    if (alu_enable_a && alu_enable_b) en_both++;
  end

  // host reference model
  int         exp_cnt = 0;
  bit         pending = 0;
  logic [7:0] e_data;
  logic       e_irq, e_err;
  int         e_lat, e_clr;
  task automatic expect_cmd(input alu_mode_e m, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (m == MODE_ILL) begin
      e_data = 8'h00; e_irq = 1'b0; e_err = 1'b1; e_lat = 1; e_clr = 0;
    end else begin
      e_data = alu_fn(m == MODE_B, op, a, b);
      e_irq  = pending || irq_hit(m == MODE_B, e_data);
      pending = 0;
      e_err  = 1'b0;
      e_lat  = e_irq ? 4 : 3;
      e_clr  = e_irq ? 1 : 0;
      if (e_irq && exp_cnt < 255) exp_cnt++;
    end
  endtask

  // observations captured by do_cmd
  logic       o_en, o_en_a, o_en_b, o_en_seen, o_irq, o_err, o_stable, o_ready_low, o_ready_after;
  logic [1:0] o_op_a, o_op_b;
  logic [7:0] o_in_a, o_in_b, o_data;
  int         o_lat, o_clr;

  task automatic tick;
    @(posedge alu_clk);
    #1;
  endtask

  task automatic do_cmd(input alu_mode_e m, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input int stall);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin tick(); w++; end
    if (!bus.cmd_ready) begin
      compared++; mismatched++;
      $display("FAIL cmd_ready_wait got 0 want 1");
    end
    bus.cmd_valid = 1'b1; bus.cmd_mode = m; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    tick();
    bus.cmd_valid = 1'b0;
    o_en = alu_enable; o_en_a = alu_enable_a; o_en_b = alu_enable_b;
    o_op_a = alu_op_a; o_op_b = alu_op_b; o_in_a = alu_in_a; o_in_b = alu_in_b;
    o_en_seen = alu_enable | alu_enable_a | alu_enable_b;
    o_clr = 0; o_lat = 0; o_ready_low = 1'b1;
    while (!bus.rsp_valid && o_lat < 20) begin
      o_ready_low &= !bus.cmd_ready;
      tick(); o_lat++;
      o_clr += int'(alu_irq_clr);
      o_en_seen |= alu_enable | alu_enable_a | alu_enable_b;
    end
    if (!bus.rsp_valid) begin
      compared++; mismatched++;
      $display("FAIL rsp_valid_wait got 0 want 1");
    end
    o_data = bus.rsp_data; o_irq = bus.rsp_irq; o_err = bus.rsp_err; o_stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      o_stable &= bus.rsp_valid && bus.rsp_data === o_data && bus.rsp_irq === o_irq && bus.rsp_err === o_err && !bus.cmd_ready;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    o_ready_after = bus.cmd_ready && !bus.rsp_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    compared++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_irq, bus.rsp_err, busy, irq_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_bus got ready=%b valid=%b data=%h irq=%b err=%b busy=%b cnt=%0d want all 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_irq, bus.rsp_err, busy, irq_count);
    end
    compared++;
    if ({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, alu_op_a, alu_op_b, alu_in_a, alu_in_b} !== '0) begin
      mismatched++;
      $display("FAIL reset_alu got en=%b%b%b clr=%b ops=%h/%h in=%h/%h want all 0",
               alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, alu_op_a, alu_op_b, alu_in_a, alu_in_b);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    compared++;
    if (bus.cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_mode_a_irq;
    expect_cmd(MODE_A, 2'b10, 8'hF0, 8'h08);
    do_cmd(MODE_A, 2'b10, 8'hF0, 8'h08, 0);
    compared++;
    if ({o_en, o_en_a, o_en_b, o_op_a, o_op_b, o_in_a, o_in_b} !== {3'b110, 2'b10, 2'b00, 8'hF0, 8'h08}) begin
      mismatched++;
      $display("FAIL a_irq_issue got en=%b%b%b op=%b/%b in=%h/%h want en=110 op=10/00 in=f0/08",
               o_en, o_en_a, o_en_b, o_op_a, o_op_b, o_in_a, o_in_b);
    end
    compared++;
    if ({o_data, o_irq, o_err} !== {8'hF8, 1'b1, 1'b0} || {o_data, o_irq, o_err} !== {e_data, e_irq, e_err}) begin
      mismatched++;
      $display("FAIL a_irq_rsp got data=%h irq=%b err=%b want data=f8 irq=1 err=0", o_data, o_irq, o_err);
    end
    compared++;
    if (o_lat !== 4 || o_clr !== 1 || irq_count !== 8'd1 || !o_ready_low) begin
      mismatched++;
      $display("FAIL a_irq_timing got lat=%0d clr=%0d cnt=%0d ready_low=%b want lat=4 clr=1 cnt=1 ready_low=1",
               o_lat, o_clr, irq_count, o_ready_low);
    end
  endtask

  task automatic test_mode_a_plain;
    expect_cmd(MODE_A, 2'b11, 8'h01, 8'h02);
    do_cmd(MODE_A, 2'b11, 8'h01, 8'h02, 0);
    compared++;
    if ({o_data, o_irq, o_err} !== {8'h03, 1'b0, 1'b0} || o_lat !== 3 || o_clr !== 0 || irq_count !== 8'(exp_cnt)) begin
      mismatched++;
      $display("FAIL a_plain got data=%h irq=%b err=%b lat=%0d clr=%0d cnt=%0d want data=03 irq=0 err=0 lat=3 clr=0 cnt=%0d",
               o_data, o_irq, o_err, o_lat, o_clr, irq_count, exp_cnt);
    end
  endtask

  task automatic test_mode_b;
    expect_cmd(MODE_B, 2'b00, 8'h0E, 8'h00);
    do_cmd(MODE_B, 2'b00, 8'h0E, 8'h00, 0);
    compared++;
    if ({o_en, o_en_a, o_en_b, o_op_a, o_op_b} !== {3'b101, 2'b00, 2'b00}) begin
      mismatched++;
      $display("FAIL b_issue got en=%b%b%b op=%b/%b want en=101 op=00/00", o_en, o_en_a, o_en_b, o_op_a, o_op_b);
    end
    compared++;
    if ({o_data, o_irq} !== {8'hF1, 1'b1} || irq_count !== 8'd2 || o_lat !== 4) begin
      mismatched++;
      $display("FAIL b_rsp got data=%h irq=%b cnt=%0d lat=%0d want data=f1 irq=1 cnt=2 lat=4", o_data, o_irq, irq_count, o_lat);
    end
  endtask

  task automatic test_illegal;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    expect_cmd(MODE_ILL, 2'($urandom), a, b);
    do_cmd(MODE_ILL, 2'b01, a, b, 0);
    compared++;
    if (o_en_seen !== 1'b0 || {o_data, o_err, o_irq} !== {8'h00, 1'b1, 1'b0} || o_lat !== 1) begin
      mismatched++;
      $display("FAIL illegal got en_seen=%b data=%h err=%b irq=%b lat=%0d want en_seen=0 data=00 err=1 irq=0 lat=1",
               o_en_seen, o_data, o_err, o_irq, o_lat);
    end
  endtask

  task automatic test_nop;
    logic bad;
    bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_NOP; bus.cmd_op = 2'b11; bus.cmd_a = 8'hAA; bus.cmd_b = 8'h55;
    tick();
    bus.cmd_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bad |= bus.rsp_valid | busy | !bus.cmd_ready | alu_enable;
      tick();
    end
    compared++;
    if (bad !== 1'b0) begin
      mismatched++;
      $display("FAIL nop got activity=%b want 0", bad);
    end
  endtask

  task automatic test_stall;
    expect_cmd(MODE_B, 2'b11, 8'hF0, 8'h0F);
    do_cmd(MODE_B, 2'b11, 8'hF0, 8'h0F, 5);
    compared++;
    if ({o_data, o_irq} !== {8'hFF, 1'b1} || !o_stable || !o_ready_after) begin
      mismatched++;
      $display("FAIL stall got data=%h irq=%b stable=%b ready_after=%b want data=ff irq=1 stable=1 ready_after=1",
               o_data, o_irq, o_stable, o_ready_after);
    end
  endtask

  task automatic test_stale_irq;
    inject_irq = 1'b1;
    tick();
    inject_irq = 1'b0;
    pending = 1;
    expect_cmd(MODE_A, 2'b11, 8'h01, 8'h02);
    do_cmd(MODE_A, 2'b11, 8'h01, 8'h02, 0);
    compared++;
    if ({o_data, o_irq} !== {8'h03, 1'b1} || o_clr !== 1 || o_lat !== 4 || irq_count !== 8'(exp_cnt)) begin
      mismatched++;
      $display("FAIL stale_irq got data=%h irq=%b clr=%0d lat=%0d cnt=%0d want data=03 irq=1 clr=1 lat=4 cnt=%0d",
               o_data, o_irq, o_clr, o_lat, irq_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_A; bus.cmd_op = 2'b10; bus.cmd_a = 8'hF0; bus.cmd_b = 8'h08;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    pending = 1;
    compared++;
    if ({busy, bus.rsp_valid, bus.cmd_ready, irq_count, alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, alu_in_a, alu_in_b} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid got busy=%b valid=%b ready=%b cnt=%0d en=%b%b%b clr=%b in=%h/%h want all 0",
               busy, bus.rsp_valid, bus.cmd_ready, irq_count, alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, alu_in_a, alu_in_b);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= bus.rsp_valid | alu_irq_clr; end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_dropped got activity=%b want 0", seen);
    end
    expect_cmd(MODE_A, 2'b11, 8'h01, 8'h02);
    do_cmd(MODE_A, 2'b11, 8'h01, 8'h02, 0);
    compared++;
    if ({o_data, o_irq, o_err} !== {e_data, e_irq, e_err} || o_lat !== e_lat || irq_count !== 8'(exp_cnt)) begin
      mismatched++;
      $display("FAIL reset_mid_next got data=%h irq=%b err=%b lat=%0d cnt=%0d want data=%h irq=%b err=%b lat=%0d cnt=%0d",
               o_data, o_irq, o_err, o_lat, irq_count, e_data, e_irq, e_err, e_lat, exp_cnt);
    end
  endtask

  task automatic test_random;
    alu_mode_e  m;
    logic [1:0] op;
    logic [7:0] a, b;
    int         stall;
    for (int n = 0; n < 40; n++) begin
      m     = alu_mode_e'($urandom_range(0, 2));
      op    = 2'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
      stall = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) begin
        inject_irq = 1'b1;
        tick();
        inject_irq = 1'b0;
        pending = 1;
      end
      expect_cmd(m, op, a, b);
      do_cmd(m, op, a, b, stall);
      compared++;
      if ({o_data, o_irq, o_err} !== {e_data, e_irq, e_err} || o_lat !== e_lat || o_clr !== e_clr ||
          irq_count !== 8'(exp_cnt) || !o_stable || !o_ready_after) begin
        mismatched++;
        $display("FAIL random[%0d] mode=%0d op=%0d a=%h b=%h got data=%h irq=%b err=%b lat=%0d clr=%0d cnt=%0d stable=%b rdy=%b want data=%h irq=%b err=%b lat=%0d clr=%0d cnt=%0d",
                 n, m, op, a, b, o_data, o_irq, o_err, o_lat, o_clr, irq_count, o_stable, o_ready_after,
                 e_data, e_irq, e_err, e_lat, e_clr, exp_cnt);
      end
    end
    compared++;
    if (en_both !== 0) begin
      mismatched++;
      $display("FAIL dual_enable got %0d cycles want 0", en_both);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_mode = MODE_NOP; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    #1;
    test_reset();
    test_mode_a_irq();
    test_mode_a_plain();
    test_mode_b();
    test_illegal();
    test_nop();
    test_stall();
    test_stale_irq();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
